// File: rtl/cpu_memory_responder_if.sv
// ----------------------------------------------------------------------------
// cpu_memory_responder_if
// Request/response signals between the CPU (plus program loader) and the
// memory responder.
//   readM1/address1/data1          : port 1, instruction fetch (read only)
//   readM2/writeM2/address2        : port 2 control; its data bus is a
//                                    separate bidirectional net on the responder
//   prog_we/prog_addr/prog_data    : program loader write request
//   prog_ready                     : loader write accepted this cycle
// master = requester side, slave = memory responder side.
// ----------------------------------------------------------------------------
interface cpu_memory_responder_if #(
   parameter int unsigned WORD_SIZE = 16
) ();
   logic                 readM1;
   logic [WORD_SIZE-1:0] address1;
   logic [WORD_SIZE-1:0] data1;
   logic                 readM2;
   logic                 writeM2;
   logic [WORD_SIZE-1:0] address2;
   logic                 prog_we;
   logic [WORD_SIZE-1:0] prog_addr;
   logic [WORD_SIZE-1:0] prog_data;
   logic                 prog_ready;

   modport master (
      output readM1, address1, readM2, writeM2, address2,
             prog_we, prog_addr, prog_data,
      input  data1, prog_ready
   );

   modport slave (
      input  readM1, address1, readM2, writeM2, address2,
             prog_we, prog_addr, prog_data,
      output data1, prog_ready
   );
endinterface

// File: rtl/cpu_memory_responder.sv
// ----------------------------------------------------------------------------
// cpu_memory_responder
// Unified word memory serving the CPU fetch port (port 1) and data port
// (port 2). Reads are combinational, writes commit on posedge clk. After
// reset the memory zeroes itself one word per cycle before serving.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   bus (slave)    : port-1/port-2 control, port-1 data, loader request
//   data2          : port-2 bidirectional data, driven only on a valid read
//   mem_ready      : clear finished, memory serving
//   num_reads      : saturating count of accepted port-1 + port-2 reads
//   num_writes     : saturating count of committed port-2 writes
//   access_err     : sticky; conflicting port-2 request or access while clearing
// ----------------------------------------------------------------------------
module cpu_memory_responder #(
   parameter int unsigned WORD_SIZE  = 16,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   cpu_memory_responder_if.slave   bus,
   inout  wire  [WORD_SIZE-1:0]    data2,
   output logic                    mem_ready,
   output logic [CNT_WIDTH-1:0]    num_reads,
   output logic [CNT_WIDTH-1:0]    num_writes,
   output logic                    access_err
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {CLEAR, READY} state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   clr_idx;
   logic [WORD_SIZE-1:0]    mem [DEPTH];

   logic                    serving_c;
   logic [ADDR_WIDTH-1:0]   idx1_c;
   logic [ADDR_WIDTH-1:0]   idx2_c;
   logic [ADDR_WIDTH-1:0]   idxp_c;
   logic                    rd2_c;
   logic                    wr2_c;
   logic                    ld_c;
   logic [1:0]              rd_inc_c;
   logic [CNT_WIDTH:0]      rd_sum_c;
   logic [CNT_WIDTH:0]      wr_sum_c;
   logic [CNT_WIDTH-1:0]    rd_next_c;
   logic [CNT_WIDTH-1:0]    wr_next_c;

   // Upper address bits are intentionally ignored (addresses wrap).
   wire unused_addr_bits = ^{bus.address1[WORD_SIZE-1:ADDR_WIDTH],
                             bus.address2[WORD_SIZE-1:ADDR_WIDTH],
                             bus.prog_addr[WORD_SIZE-1:ADDR_WIDTH]};

   // Request decode
   assign serving_c = (state == READY);
   assign idx1_c    = bus.address1[ADDR_WIDTH-1:0];
   assign idx2_c    = bus.address2[ADDR_WIDTH-1:0];
   assign idxp_c    = bus.prog_addr[ADDR_WIDTH-1:0];
   assign rd2_c     = serving_c & bus.readM2 & ~bus.writeM2;
   assign wr2_c     = serving_c & bus.writeM2 & ~bus.readM2;
   assign ld_c      = bus.prog_we & bus.prog_ready;

   // Read paths return the pre-edge contents: no write bypass.
   assign bus.data1      = (serving_c && bus.readM1) ? mem[idx1_c] : '0;
   assign data2          = rd2_c ? mem[idx2_c] : 'z;
   assign bus.prog_ready = mem_ready & ~wr2_c;

   // Saturating counter updates; one extra bit catches the overflow.
   assign rd_inc_c  = 2'(bus.readM1) + 2'(rd2_c);
   assign rd_sum_c  = (CNT_WIDTH+1)'(num_reads) + (CNT_WIDTH+1)'(rd_inc_c);
   assign wr_sum_c  = (CNT_WIDTH+1)'(num_writes) + (CNT_WIDTH+1)'(wr2_c);
   assign rd_next_c = rd_sum_c[CNT_WIDTH] ? '1 : rd_sum_c[CNT_WIDTH-1:0];
   assign wr_next_c = wr_sum_c[CNT_WIDTH] ? '1 : wr_sum_c[CNT_WIDTH-1:0];

   // Memory array: clear sweep, then CPU write, then loader write.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[clr_idx] <= '0;
      end else if (wr2_c) begin
         mem[idx2_c] <= data2;
      end else if (ld_c) begin
         mem[idxp_c] <= bus.prog_data;
      end
   end

   // Control FSM, counters and error flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= CLEAR;
         clr_idx    <= '0;
         mem_ready  <= 1'b0;
         num_reads  <= '0;
         num_writes <= '0;
         access_err <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               clr_idx <= clr_idx + ADDR_WIDTH'(1);
               if (&clr_idx) begin
                  state     <= READY;
                  mem_ready <= 1'b1;
               end
               if (bus.readM1 | bus.readM2 | bus.writeM2) begin
                  access_err <= 1'b1;
               end
            end
            READY: begin
               num_reads  <= rd_next_c;
               num_writes <= wr_next_c;
               if (bus.readM2 & bus.writeM2) begin
                  access_err <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_memory_responder.sv
// ----------------------------------------------------------------------------
// tb_cpu_memory_responder
// Directed bench for cpu_memory_responder with a 16-word memory. data2 has a
// pull-up, so an undriven bus reads back as 16'hFFFF.
// ----------------------------------------------------------------------------
module tb_cpu_memory_responder;

   localparam int unsigned W  = 16;
   localparam int unsigned AW = 4;
   localparam int unsigned CW = 16;

   logic           clk = 1'b0;
   logic           reset_n;
   wire  [W-1:0]   data2;
   logic           tb_drv_en;
   logic [W-1:0]   tb_drv;
   logic           mem_ready;
   logic [CW-1:0]  num_reads;
   logic [CW-1:0]  num_writes;
   logic           access_err;

   int n_pass  = 0;
   int n_total = 0;

   cpu_memory_responder_if #(.WORD_SIZE(W)) bus ();

   cpu_memory_responder #(
      .WORD_SIZE  (W),
      .ADDR_WIDTH (AW),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .data2      (data2),
      .mem_ready  (mem_ready),
      .num_reads  (num_reads),
      .num_writes (num_writes),
      .access_err (access_err)
   );

   assign data2 = tb_drv_en ? tb_drv : 'z;
   pullup (data2);

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.readM1   = 1'b0;
      bus.readM2   = 1'b0;
      bus.writeM2  = 1'b0;
      bus.prog_we  = 1'b0;
      tb_drv_en    = 1'b0;
   endtask

   initial begin
      reset_n       = 1'b0;
      bus.address1  = '0;
      bus.address2  = '0;
      bus.prog_addr = '0;
      bus.prog_data = '0;
      tb_drv        = '0;
      idle();

      // Reset state
      repeat (3) step();
      chk("rst_mem_ready",  32'(mem_ready),      32'h0);
      chk("rst_num_reads",  32'(num_reads),      32'h0);
      chk("rst_num_writes", 32'(num_writes),     32'h0);
      chk("rst_access_err", 32'(access_err),     32'h0);
      chk("rst_prog_ready", 32'(bus.prog_ready), 32'h0);

      // Clear sequence: fetch during clear flags an error but is not counted
      reset_n      = 1'b1;
      bus.readM1   = 1'b1;
      bus.address1 = 16'h0002;
      #1;
      chk("clr_data1", 32'(bus.data1), 32'h0);
      step();
      bus.readM1 = 1'b0;
      chk("clr_err", 32'(access_err), 32'h1);
      repeat (14) step();
      chk("clr_not_ready_15", 32'(mem_ready), 32'h0);
      step();
      chk("clr_ready_16", 32'(mem_ready), 32'h1);
      chk("clr_reads_0",  32'(num_reads), 32'h0);

      // Cleared contents read as zero
      bus.readM1   = 1'b1;
      bus.address1 = 16'h0007;
      bus.readM2   = 1'b1;
      bus.address2 = 16'h000F;
      #1;
      chk("zero_data1", 32'(bus.data1), 32'h0);
      chk("zero_data2", 32'(data2),     32'h0);
      step();
      idle();
      chk("zero_reads", 32'(num_reads), 32'd2);

      // Loader write, then fetch it back
      bus.prog_we   = 1'b1;
      bus.prog_addr = 16'h0003;
      bus.prog_data = 16'h1234;
      #1;
      chk("ld_prog_ready", 32'(bus.prog_ready), 32'h1);
      step();
      idle();
      bus.readM1   = 1'b1;
      bus.address1 = 16'h0003;
      #1;
      chk("ld_data1", 32'(bus.data1), 32'h1234);
      step();
      idle();
      chk("ld_reads", 32'(num_reads), 32'd3);

      // CPU write with same-cycle fetch of that address sees the old value
      bus.writeM2  = 1'b1;
      bus.address2 = 16'h0005;
      tb_drv       = 16'hBEEF;
      tb_drv_en    = 1'b1;
      bus.readM1   = 1'b1;
      bus.address1 = 16'h0005;
      #1;
      chk("wr_old_data1", 32'(bus.data1), 32'h0);
      step();
      idle();
      bus.readM2   = 1'b1;
      bus.address2 = 16'h0005;
      #1;
      chk("wr_data2",  32'(data2),      32'hBEEF);
      chk("wr_writes", 32'(num_writes), 32'd1);
      chk("wr_reads",  32'(num_reads),  32'd4);
      step();
      idle();
      chk("rd2_reads", 32'(num_reads), 32'd5);

      // CPU write blocks loader; loader holds and commits the cycle after
      bus.writeM2   = 1'b1;
      bus.address2  = 16'h0006;
      tb_drv        = 16'h1111;
      tb_drv_en     = 1'b1;
      bus.prog_we   = 1'b1;
      bus.prog_addr = 16'h0007;
      bus.prog_data = 16'h2222;
      #1;
      chk("blk_prog_ready_0", 32'(bus.prog_ready), 32'h0);
      step();
      bus.writeM2 = 1'b0;
      tb_drv_en   = 1'b0;
      #1;
      chk("blk_prog_ready_1", 32'(bus.prog_ready), 32'h1);
      step();
      idle();
      bus.readM1   = 1'b1;
      bus.address1 = 16'h0006;
      bus.readM2   = 1'b1;
      bus.address2 = 16'h0007;
      #1;
      chk("blk_cpu_val",    32'(bus.data1), 32'h1111);
      chk("blk_loader_val", 32'(data2),     32'h2222);
      step();
      idle();
      chk("blk_reads",  32'(num_reads),  32'd7);
      chk("blk_writes", 32'(num_writes), 32'd2);

      // Conflicting port-2 request: bus undriven, nothing written or counted
      bus.readM2   = 1'b1;
      bus.writeM2  = 1'b1;
      bus.address2 = 16'h0007;
      #1;
      chk("conf_hiz", 32'(data2), 32'hFFFF);
      step();
      idle();
      chk("conf_reads",  32'(num_reads),  32'd7);
      chk("conf_writes", 32'(num_writes), 32'd2);
      bus.readM1   = 1'b1;
      bus.address1 = 16'h0007;
      #1;
      chk("conf_mem_kept", 32'(bus.data1), 32'h2222);
      step();
      idle();

      // Address aliasing on read and write
      bus.readM1   = 1'b1;
      bus.address1 = 16'h0013;
      #1;
      chk("alias_rd", 32'(bus.data1), 32'h1234);
      step();
      idle();
      bus.writeM2  = 1'b1;
      bus.address2 = 16'h0025;
      tb_drv       = 16'hA5A5;
      tb_drv_en    = 1'b1;
      step();
      idle();
      bus.readM1   = 1'b1;
      bus.address1 = 16'h0005;
      #1;
      chk("alias_wr", 32'(bus.data1), 32'hA5A5);
      step();
      idle();
      chk("alias_reads",  32'(num_reads),  32'd10);
      chk("alias_writes", 32'(num_writes), 32'd3);

      // Read counter saturation with two reads per cycle
      bus.readM1   = 1'b1;
      bus.address1 = 16'h0000;
      bus.readM2   = 1'b1;
      bus.address2 = 16'h0000;
      repeat (32762) step();
      chk("sat_below", 32'(num_reads), 32'hFFFE);
      step();
      chk("sat_hit", 32'(num_reads), 32'hFFFF);
      step();
      chk("sat_hold", 32'(num_reads), 32'hFFFF);
      idle();

      // Asynchronous reset in the middle of a write cycle
      bus.writeM2  = 1'b1;
      bus.address2 = 16'h0009;
      tb_drv       = 16'h7777;
      tb_drv_en    = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_mem_ready", 32'(mem_ready),  32'h0);
      chk("arst_reads",     32'(num_reads),  32'h0);
      chk("arst_writes",    32'(num_writes), 32'h0);
      chk("arst_err",       32'(access_err), 32'h0);
      step();
      idle();
      step();
      reset_n = 1'b1;
      repeat (15) step();
      chk("arst_not_ready_15", 32'(mem_ready), 32'h0);
      step();
      chk("arst_ready_16", 32'(mem_ready),  32'h1);
      chk("arst_err_idle", 32'(access_err), 32'h0);
      bus.readM1   = 1'b1;
      bus.address1 = 16'h0009;
      bus.readM2   = 1'b1;
      bus.address2 = 16'h0003;
      #1;
      chk("arst_dropped", 32'(bus.data1), 32'h0);
      chk("arst_cleared", 32'(data2),     32'h0);
      step();
      idle();

      // Conflicting port-2 request sets the sticky error
      bus.readM2  = 1'b1;
      bus.writeM2 = 1'b1;
      step();
      idle();
      chk("err_set", 32'(access_err), 32'h1);
      step();
      chk("err_sticky", 32'(access_err), 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
